// File: rtl/branch_target_predictor.sv
// IF-stage direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational from registered state; EX-stage outcomes train it on the next edge.
module branch_target_predictor #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_F,
    output logic              hit_F,
    output logic              prediction_F,
    output logic [ADDR_W-1:0] target_F,
    input  logic              upd_valid_E,
    input  logic [ADDR_W-1:0] pc_E,
    input  logic              taken_E,
    input  logic [ADDR_W-1:0] target_E,
    input  logic              hit_E,
    input  logic              prediction_E,
    output logic [CNT_W-1:0]  mispredict_cnt
);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int          TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              valid_q [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [ADDR_W-1:0] tgt_q   [DEPTH];
    logic [1:0]        ctr_q   [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0]  idx_F, idx_E;
    logic [TAG_W-1:0]  tag_F, tag_E;
    logic              ent_hit_E, wr_en, mispredict;
    logic              valid_d;
    logic [TAG_W-1:0]  tag_d;
    logic [ADDR_W-1:0] tgt_d;
    logic [1:0]        ctr_d;

    assign idx_F = pc_F[IDX_W-1:0];
    assign tag_F = pc_F[ADDR_W-1:IDX_W];
    assign idx_E = pc_E[IDX_W-1:0];
    assign tag_E = pc_E[ADDR_W-1:IDX_W];

    assign hit_F          = valid_q[idx_F] && (tag_q[idx_F] == tag_F);
    assign prediction_F   = hit_F && ctr_q[idx_F][1];
    assign target_F       = hit_F ? tgt_q[idx_F] : '0;
    assign mispredict_cnt = cnt_q;

    assign ent_hit_E  = valid_q[idx_E] && (tag_q[idx_E] == tag_E);
    assign mispredict = upd_valid_E &&
                        ((hit_E && (prediction_E != taken_E)) || (!hit_E && taken_E));

    always_comb begin
        wr_en   = 1'b0;
        valid_d = valid_q[idx_E];
        tag_d   = tag_q[idx_E];
        tgt_d   = tgt_q[idx_E];
        ctr_d   = ctr_q[idx_E];
        if (upd_valid_E) begin
            if (ent_hit_E) begin
                wr_en = 1'b1;
                if (taken_E) begin
                    ctr_d = (ctr_q[idx_E] == 2'b11) ? 2'b11 : ctr_q[idx_E] + 2'd1;
                    tgt_d = target_E;
                end else begin
                    ctr_d = (ctr_q[idx_E] == 2'b00) ? 2'b00 : ctr_q[idx_E] - 2'd1;
                end
            end else if (taken_E) begin
                // Not-taken misses leave any resident victim entry alone.
                wr_en   = 1'b1;
                valid_d = 1'b1;
                tag_d   = tag_E;
                tgt_d   = target_E;
                ctr_d   = 2'b10;
            end
        end
        cnt_d = (mispredict && (cnt_q != '1)) ? cnt_q + CNT_ONE : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[idx_E] <= valid_d;
                tag_q[idx_E]   <= tag_d;
                tgt_q[idx_E]   <= tgt_d;
                ctr_q[idx_E]   <= ctr_d;
            end
            cnt_q <= cnt_d;
        end
    end
endmodule
